// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller.
// Read hits return data combinationally; misses and stores sequence main memory.
module dcache_ctrl #(
   parameter int DATA  = 32,
   parameter int ADDR  = 32,
   parameter int LINES = 64
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            MemRead,
   input  logic            MemWrite,
   input  logic [ADDR-1:0] A,
   input  logic [DATA-1:0] WD,
   output logic [DATA-1:0] RD,
   output logic            stall,
   output logic            mem_req,
   output logic            mem_we,
   output logic [ADDR-1:0] mem_addr,
   output logic [DATA-1:0] mem_wdata,
   input  logic [DATA-1:0] mem_rdata,
   input  logic            mem_ready
);

   localparam int IDX = $clog2(LINES);
   localparam int TAG = ADDR - IDX - 2;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_FILL  = 2'd1;
   localparam logic [1:0] S_WRITE = 2'd2;

   logic [1:0]      state_q, state_d;
   logic            mem_req_q, mem_req_d;
   logic            mem_we_q, mem_we_d;
   logic [ADDR-1:0] mem_addr_q, mem_addr_d;
   logic [DATA-1:0] mem_wdata_q, mem_wdata_d;

   logic [DATA-1:0] data_q [LINES];
   logic [TAG-1:0]  tag_q  [LINES];
   logic [LINES-1:0] valid_q;

   logic [IDX-1:0]  idx_s;
   logic [TAG-1:0]  tag_s;
   logic [IDX-1:0]  fill_idx_s;
   logic [TAG-1:0]  fill_tag_s;
   logic            hit_s;
   logic            stall_s;
   logic            store_hit_we_s;
   logic            fill_we_s;
   logic            unused_addr_lsb_s;

   assign idx_s      = A[IDX+1:2];
   assign tag_s      = A[ADDR-1:IDX+2];
   // The core holds its request during a fill, so the latched address names the line.
   assign fill_idx_s = mem_addr_q[IDX+1:2];
   assign fill_tag_s = mem_addr_q[ADDR-1:IDX+2];
   assign hit_s      = valid_q[idx_s] & (tag_q[idx_s] == tag_s);
   assign unused_addr_lsb_s = &{1'b0, A[1:0]};

   assign RD        = data_q[idx_s];
   assign stall     = stall_s;
   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;

   // Next-state, memory request and stall decode.
   always_comb begin
      state_d        = state_q;
      mem_req_d      = mem_req_q;
      mem_we_d       = mem_we_q;
      mem_addr_d     = mem_addr_q;
      mem_wdata_d    = mem_wdata_q;
      stall_s        = 1'b0;
      store_hit_we_s = 1'b0;
      fill_we_s      = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (MemWrite) begin
               mem_addr_d     = A;
               mem_wdata_d    = WD;
               mem_req_d      = 1'b1;
               mem_we_d       = 1'b1;
               state_d        = S_WRITE;
               stall_s        = 1'b1;
               store_hit_we_s = hit_s;
            end else if (MemRead && !hit_s) begin
               mem_addr_d = A;
               mem_req_d  = 1'b1;
               mem_we_d   = 1'b0;
               state_d    = S_FILL;
               stall_s    = 1'b1;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_FILL: begin
            stall_s = 1'b1;
            if (mem_ready) begin
               mem_req_d = 1'b0;
               fill_we_s = 1'b1;
               state_d   = S_IDLE;
            end else begin
               state_d = S_FILL;
            end
         end
         S_WRITE: begin
            stall_s = ~mem_ready;
            if (mem_ready) begin
               mem_req_d = 1'b0;
               state_d   = S_IDLE;
            end else begin
               state_d = S_WRITE;
            end
         end
         default: begin
            mem_req_d = 1'b0;
            state_d   = S_IDLE;
         end
      endcase
   end

   // Control state, memory interface registers and valid bits.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= {ADDR{1'b0}};
         mem_wdata_q <= {DATA{1'b0}};
         valid_q     <= {LINES{1'b0}};
      end else begin
         state_q     <= state_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         if (fill_we_s) begin
            valid_q[fill_idx_s] <= 1'b1;
         end
      end
   end

   // Data and tag arrays carry no reset; the valid bits guard them.
   always_ff @(posedge clk) begin
      if (rst_n && store_hit_we_s) begin
         data_q[idx_s] <= WD;
      end else if (rst_n && fill_we_s) begin
         data_q[fill_idx_s] <= mem_rdata;
         tag_q[fill_idx_s]  <= fill_tag_s;
      end
   end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Scoreboard bench for dcache_ctrl: expected load data and memory transactions
// are queued as stimulus is driven and compared as the DUT and memory model complete them.
module tb_dcache_ctrl;

   localparam int LAT = 3;

   logic        clk;
   logic        rst_n;
   logic        MemRead, MemWrite;
   logic [31:0] A, WD, RD;
   logic        stall;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_ready;

   int n_vec = 0;
   int n_mis = 0;
   int req_rises = 0;
   int mcnt = 0;
   logic prev_req = 1'b0;

   logic [31:0] ref_mem [logic [31:0]];
   logic [31:0] mem_arr [logic [31:0]];
   logic [31:0] exp_rd_q[$];
   logic [31:0] exp_raddr_q[$];
   logic [63:0] exp_wr_q[$];

   dcache_ctrl #(.DATA(32), .ADDR(32), .LINES(64)) dut (
      .clk(clk), .rst_n(rst_n), .MemRead(MemRead), .MemWrite(MemWrite),
      .A(A), .WD(WD), .RD(RD), .stall(stall),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] dflt(input logic [31:0] a);
      return a ^ 32'hC0DE_0000;
   endfunction

   function automatic logic [31:0] ref_of(input logic [31:0] a);
      if (ref_mem.exists(a)) return ref_mem[a];
      else return dflt(a);
   endfunction

   // Main memory model: ready pulse in the LAT-th cycle of a held request.
   initial begin
      mem_ready = 1'b0;
      mem_rdata = 32'h0;
      forever begin
         @(posedge clk);
         #1;
         mem_ready = 1'b0;
         if (mem_req && !prev_req) req_rises++;
         prev_req = mem_req;
         if (mem_req) begin
            mcnt++;
            if (mcnt == LAT) begin
               mem_ready = 1'b1;
               if (mem_we) begin
                  if (exp_wr_q.size() == 0) begin
                     check_val("unexpected_write", mem_addr, 32'hFFFF_FFFF);
                  end else begin
                     logic [63:0] w;
                     w = exp_wr_q.pop_front();
                     check_val("wr_addr", mem_addr, w[63:32]);
                     check_val("wr_data", mem_wdata, w[31:0]);
                  end
                  mem_arr[mem_addr] = mem_wdata;
               end else begin
                  if (exp_raddr_q.size() == 0) begin
                     check_val("unexpected_read", mem_addr, 32'hFFFF_FFFF);
                  end else begin
                     check_val("rd_addr", mem_addr, exp_raddr_q.pop_front());
                  end
                  mem_rdata = mem_arr.exists(mem_addr) ? mem_arr[mem_addr] : dflt(mem_addr);
               end
            end
         end else begin
            mcnt = 0;
         end
      end
   end

   task automatic do_load(input logic [31:0] a, input int exp_stall, input bit miss);
      int n;
      int r0;
      bit done;
      n = 0;
      done = 1'b0;
      @(posedge clk);
      #2;
      MemRead = 1'b1; MemWrite = 1'b0; A = a; WD = $urandom;
      exp_rd_q.push_back(ref_of(a));
      if (miss) exp_raddr_q.push_back(a);
      r0 = req_rises;
      while (!done && n < 40) begin
         @(negedge clk);
         if (!stall) begin
            check_val("rd_data", RD, exp_rd_q.pop_front());
            done = 1'b1;
         end else begin
            n++;
         end
      end
      if (!done) begin
         check_val("load_timeout", 32'd0, 32'd1);
         void'(exp_rd_q.pop_front());
      end
      check_val("load_stall_cycles", n, exp_stall);
      check_val("load_req_count", req_rises - r0, miss ? 32'd1 : 32'd0);
   endtask

   task automatic do_store(input logic [31:0] a, input logic [31:0] d, input bit with_read);
      int n;
      int r0;
      bit done;
      n = 0;
      done = 1'b0;
      @(posedge clk);
      #2;
      MemWrite = 1'b1; MemRead = with_read; A = a; WD = d;
      ref_mem[a] = d;
      exp_wr_q.push_back({a, d});
      r0 = req_rises;
      while (!done && n < 40) begin
         @(negedge clk);
         if (!stall) begin
            check_val("st_mem_req", mem_req, 32'd1);
            check_val("st_mem_we", mem_we, 32'd1);
            check_val("st_mem_addr", mem_addr, a);
            check_val("st_mem_wdata", mem_wdata, d);
            done = 1'b1;
         end else begin
            n++;
         end
      end
      if (!done) check_val("store_timeout", 32'd0, 32'd1);
      check_val("store_stall_cycles", n, LAT);
      check_val("store_req_count", req_rises - r0, 32'd1);
   endtask

   initial begin
      rst_n = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; A = 32'h0; WD = 32'h0;
      ref_mem[32'h40] = 32'hDEAD_BEEF;
      mem_arr[32'h40] = 32'hDEAD_BEEF;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_val("rst_mem_req", mem_req, 32'd0);
      check_val("rst_mem_we", mem_we, 32'd0);
      check_val("rst_mem_addr", mem_addr, 32'd0);
      check_val("rst_mem_wdata", mem_wdata, 32'd0);
      check_val("rst_stall", stall, 32'd0);
      @(posedge clk);
      #2 rst_n = 1'b1;

      do_load(32'h40, LAT + 1, 1'b1);
      do_load(32'h40, 0, 1'b0);
      do_store(32'h40, 32'h1234_5678, 1'b0);
      do_load(32'h40, 0, 1'b0);
      do_store(32'h80, 32'hCAFE_F00D, 1'b0);
      do_load(32'h80, LAT + 1, 1'b1);
      do_load(32'h40, 0, 1'b0);
      do_load(32'h140, LAT + 1, 1'b1);
      do_load(32'h40, LAT + 1, 1'b1);

      // Reset in the middle of a fill abandons it.
      @(posedge clk);
      #2 MemRead = 1'b1; MemWrite = 1'b0; A = 32'h200;
      @(posedge clk);
      @(negedge clk);
      check_val("fill_req_up", mem_req, 32'd1);
      @(posedge clk);
      #2 rst_n = 1'b0; MemRead = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check_val("rst_fill_req", mem_req, 32'd0);
      check_val("rst_fill_idle", stall, 32'd0);
      @(posedge clk);
      #2 rst_n = 1'b1;
      do_load(32'h40, LAT + 1, 1'b1);

      do_store(32'h40, 32'hA5A5_1234, 1'b1);
      do_load(32'h40, 0, 1'b0);

      @(posedge clk);
      #2 MemRead = 1'b0; MemWrite = 1'b0;
      repeat (LAT + 2) @(posedge clk);
      @(negedge clk);
      check_val("raddr_q_drained", exp_raddr_q.size(), 32'd0);
      check_val("wr_q_drained", exp_wr_q.size(), 32'd0);
      check_val("idle_req", mem_req, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
